// File: rtl/nn_host_ctrl.sv
// nn_host_ctrl: byte-stream host FSM that loads weights/pixels into the network, pulses learn/classify and returns the result.
// Last pixel byte to res_valid is RESULT_LAT+2 cycles; res held until res_ready; define NN_HOST_CMD_ERR_EN to add the err pulse.
module nn_host_ctrl #(
  parameter int RESULT_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic [3:0][7:0] pixels,
  output logic [31:0]     KIDATA1,
  output logic [31:0]     KIDATA2,
  output logic [31:0]     W1IDATA1,
  output logic [31:0]     W1IDATA2,
  output logic [31:0]     W2IDATA1,
  output logic [31:0]     W2IDATA2,
  output logic            learn,
  output logic            classify,
  input  logic [7:0]      result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [7:0]      res_data,
`ifdef NN_HOST_CMD_ERR_EN
  output logic            err,
`endif
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LEARN,
    LOAD_PIX,
    CLASSIFY,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] OP_LOAD_W   = 8'h01;
  localparam logic [7:0] OP_LOAD_PIX = 8'h02;
  localparam logic [7:0] WAIT_INIT   = 8'(RESULT_LAT);

  state_t               r_state;
  logic [4:0]           r_cnt;
  logic [7:0]           r_wait;
  logic [5:0][3:0][7:0] r_wsh;
  logic [5:0][3:0][7:0] w_wsh;
  logic [3:0][7:0]      r_psh;
  logic [3:0][7:0]      w_psh;
  logic [5:0][31:0]     r_w;
  logic [3:0][7:0]      r_pix;
  logic                 r_learn;
  logic                 r_classify;
  logic                 r_res_valid;
  logic [7:0]           r_res_data;
  logic                 w_acc;

  assign in_ready = (r_state == IDLE) || (r_state == LOAD_W) || (r_state == LOAD_PIX);
  assign w_acc    = in_valid && in_ready;
  assign busy     = (r_state != IDLE);

  // Shadow view including the byte being accepted this cycle, so the final byte lands in the commit.
  always_comb begin
    w_wsh = r_wsh;
    w_psh = r_psh;
    if (w_acc && (r_state == LOAD_W)) begin
      w_wsh[r_cnt[4:2]][r_cnt[1:0]] = in_data;
    end
    if (w_acc && (r_state == LOAD_PIX)) begin
      w_psh[r_cnt[1:0]] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_wsh       <= '0;
      r_psh       <= '0;
      r_w         <= '0;
      r_pix       <= '0;
      r_learn     <= 1'b0;
      r_classify  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_learn    <= 1'b0;
      r_classify <= 1'b0;
      r_wsh      <= w_wsh;
      r_psh      <= w_psh;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_acc) begin
            if (in_data == OP_LOAD_W) begin
              r_state <= LOAD_W;
            end else if (in_data == OP_LOAD_PIX) begin
              r_state <= LOAD_PIX;
            end
          end
        end
        LOAD_W: begin
          if (w_acc) begin
            if (r_cnt == 5'd23) begin
              r_w     <= w_wsh;
              r_learn <= 1'b1;
              r_cnt   <= '0;
              r_state <= LEARN;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        LEARN: begin
          r_state <= IDLE;
        end
        LOAD_PIX: begin
          if (w_acc) begin
            if (r_cnt == 5'd3) begin
              r_pix      <= w_psh;
              r_classify <= 1'b1;
              r_cnt      <= '0;
              r_state    <= CLASSIFY;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        CLASSIFY: begin
          r_wait  <= WAIT_INIT;
          r_state <= WAIT;
        end
        WAIT: begin
          // Last WAIT cycle samples the network output.
          if (r_wait <= 8'd1) begin
            r_wait      <= '0;
            r_res_data  <= result;
            r_res_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_wait <= r_wait - 8'd1;
          end
        end
        RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef NN_HOST_CMD_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_acc && (r_state == IDLE) &&
               (in_data != OP_LOAD_W) && (in_data != OP_LOAD_PIX);
    end
  end

  assign err = r_err;
`endif

  assign pixels    = r_pix;
  assign KIDATA1   = r_w[0];
  assign KIDATA2   = r_w[1];
  assign W1IDATA1  = r_w[2];
  assign W1IDATA2  = r_w[3];
  assign W2IDATA1  = r_w[4];
  assign W2IDATA2  = r_w[5];
  assign learn     = r_learn;
  assign classify  = r_classify;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_nn_host_ctrl.sv
// Bench for nn_host_ctrl: timeline reference model checked every cycle, plus directed literal checks.
module tb_nn_host_ctrl;
  localparam int RL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic [3:0][7:0] pixels;
  logic [31:0]     KIDATA1, KIDATA2, W1IDATA1, W1IDATA2, W2IDATA1, W2IDATA2;
  logic            learn, classify;
  logic [7:0]      result;
  logic            res_valid, res_ready;
  logic [7:0]      res_data;
  logic            busy;
`ifdef NN_HOST_CMD_ERR_EN
  logic            err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pcyc = 0;
  int learn_cnt = 0;
  int classify_cnt = 0;

  nn_host_ctrl #(.RESULT_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pixels(pixels),
    .KIDATA1(KIDATA1), .KIDATA2(KIDATA2),
    .W1IDATA1(W1IDATA1), .W1IDATA2(W1IDATA2),
    .W2IDATA1(W2IDATA1), .W2IDATA2(W2IDATA2),
    .learn(learn), .classify(classify),
    .result(result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef NN_HOST_CMD_ERR_EN
    .err(err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  logic [31:0] dw [6];
  always_comb begin
    dw[0] = KIDATA1;  dw[1] = KIDATA2;
    dw[2] = W1IDATA1; dw[3] = W1IDATA2;
    dw[4] = W2IDATA1; dw[5] = W2IDATA2;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command is either being collected (m_cmd) or executing on a
  // timeline anchored at m_done, the first cycle after the committing byte.
  logic [31:0]  m_w [6];
  logic [31:0]  m_pix;
  logic [7:0]   m_res;
  byte unsigned m_q [$];
  int           m_cmd = 0;   // 0 expecting opcode, 1 weight bytes, 2 pixel bytes
  int           m_kind = 0;  // 0 none, 1 learning, 2 classifying/responding
  int           m_done = 0;
  logic         m_err = 1'b0;
  logic         e_err_nxt;

  always @(negedge clk) begin
    if (rst) begin
      m_cmd = 0; m_kind = 0; m_q.delete(); m_res = '0; m_pix = '0; m_err = 1'b0;
      for (int i = 0; i < 6; i++) m_w[i] = '0;
      chk("rst_busy", busy, 0);
      chk("rst_learn", learn, 0);
      chk("rst_classify", classify, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_pixels", pixels, 0);
      for (int i = 0; i < 6; i++) chk($sformatf("rst_weight%0d", i), dw[i], 0);
    end else begin
      chk("m_in_ready", in_ready, (m_kind == 0));
      chk("m_busy", busy, (m_kind != 0) || (m_cmd != 0));
      chk("m_learn", learn, (m_kind == 1) && (pcyc == m_done));
      chk("m_classify", classify, (m_kind == 2) && (pcyc == m_done));
      chk("m_res_valid", res_valid, (m_kind == 2) && (pcyc >= m_done + RL + 1));
      chk("m_res_data", res_data, m_res);
      chk("m_pixels", pixels, m_pix);
      for (int i = 0; i < 6; i++) chk($sformatf("m_weight%0d", i), dw[i], m_w[i]);
`ifdef NN_HOST_CMD_ERR_EN
      chk("m_err", err, m_err);
`endif
      if (learn) learn_cnt++;
      if (classify) classify_cnt++;

      e_err_nxt = 1'b0;
      if (m_kind == 0) begin
        if (in_valid) begin
          if (m_cmd == 0) begin
            if (in_data == 8'h01) m_cmd = 1;
            else if (in_data == 8'h02) m_cmd = 2;
            else e_err_nxt = 1'b1;
          end else begin
            m_q.push_back(in_data);
            if (m_cmd == 1 && m_q.size() == 24) begin
              for (int i = 0; i < 24; i++) m_w[i / 4][8 * (i % 4) +: 8] = m_q[i];
              m_kind = 1; m_done = pcyc + 1; m_cmd = 0; m_q.delete();
            end else if (m_cmd == 2 && m_q.size() == 4) begin
              for (int i = 0; i < 4; i++) m_pix[8 * i +: 8] = m_q[i];
              m_kind = 2; m_done = pcyc + 1; m_cmd = 0; m_q.delete();
            end
          end
        end
      end else if (m_kind == 1) begin
        m_kind = 0;
      end else begin
        if (pcyc == m_done + RL) m_res = result;
        if (pcyc >= m_done + RL + 1 && res_ready) m_kind = 0;
      end
      m_err = e_err_nxt;
    end
  end

  logic [7:0] wbuf [24];
  logic [7:0] pbuf [4];

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns the cycle index during which the byte sat on the bus with in_ready high.
  task automatic send_byte(input logic [7:0] b, output int t_acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        chk("in_ready_timeout", in_ready, 1);
        break;
      end
    end
    t_acc = pcyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic load_weights(input int gap_mode);
    int t;
    send_byte(8'h01, t);
    for (int i = 0; i < 24; i++) begin
      send_byte(wbuf[i], t);
      if (gap_mode == 1) tick(1);
      else if (gap_mode == 2) tick($urandom_range(0, 2));
    end
  endtask

  task automatic load_pixels(input int gap_mode, output int t_last);
    int t;
    send_byte(8'h02, t);
    for (int i = 0; i < 4; i++) begin
      send_byte(pbuf[i], t_last);
      if (gap_mode == 2 && i < 3) tick($urandom_range(0, 2));
    end
  endtask

  task automatic wait_resp(input bit garbage, output int t_seen);
    int n;
    n = 0;
    t_seen = -1;
    while (n < 400) begin
      @(negedge clk);
      if (res_valid) begin
        t_seen = pcyc;
        break;
      end
      @(posedge clk); #1;
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        result   = 8'($urandom);
      end
      n++;
    end
    if (t_seen < 0) chk("res_valid_timeout", res_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic release_resp(input int hold, input bit garbage);
    for (int i = 0; i < hold; i++) begin
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        result   = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic check_seq_weights(input string tag);
    chk({tag, "_KIDATA1"},  KIDATA1,  32'h03020100);
    chk({tag, "_KIDATA2"},  KIDATA2,  32'h07060504);
    chk({tag, "_W1IDATA1"}, W1IDATA1, 32'h0B0A0908);
    chk({tag, "_W1IDATA2"}, W1IDATA2, 32'h0F0E0D0C);
    chk({tag, "_W2IDATA1"}, W2IDATA1, 32'h13121110);
    chk({tag, "_W2IDATA2"}, W2IDATA2, 32'h17161514);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t_last, t_seen, l0, c0, sel;
    logic [7:0] op;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; result = '0; res_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Sequential weight load, back-to-back bytes.
    for (int i = 0; i < 24; i++) wbuf[i] = 8'(i);
    l0 = learn_cnt;
    load_weights(0);
    tick(2);
    check_seq_weights("wload");
    chk("wload_learn_pulses", learn_cnt - l0, 1);
    chk("wload_busy_after", busy, 0);

    // Classify with fixed result and exact latency.
    result = 8'h5A;
    pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33; pbuf[3] = 8'h44;
    c0 = classify_cnt;
    load_pixels(0, t_last);
    wait_resp(1'b0, t_seen);
    chk("cls_latency", t_seen - t_last, 6);
    chk("cls_pixels", pixels, 32'h44332211);
    chk("cls_res_data", res_data, 8'h5A);
    chk("cls_pulses", classify_cnt - c0, 1);
    release_resp(0, 1'b0);
    tick(1);

    // Response backpressure with result wiggling underneath.
    result = 8'hC3;
    pbuf[0] = 8'hDE; pbuf[1] = 8'hAD; pbuf[2] = 8'hBE; pbuf[3] = 8'hEF;
    load_pixels(0, t_last);
    wait_resp(1'b0, t_seen);
    for (int i = 0; i < 10; i++) begin
      result = 8'($urandom);
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 8'hC3);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_res_valid", res_valid, 0);
    chk("bp_idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Unknown opcode followed by a normal classify.
    send_byte(8'h7F, t);
    @(negedge clk);
    chk("unk_busy", busy, 0);
`ifdef NN_HOST_CMD_ERR_EN
    chk("unk_err", err, 1);
`endif
    @(posedge clk); #1;
    result = 8'h3C;
    pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03; pbuf[3] = 8'h04;
    load_pixels(0, t_last);
    wait_resp(1'b0, t_seen);
    chk("unk_then_pixels", pixels, 32'h04030201);
    chk("unk_then_res", res_data, 8'h3C);
    release_resp(2, 1'b0);

    // Scramble the weights, then reload the sequence with in_valid toggling.
    for (int i = 0; i < 24; i++) wbuf[i] = 8'($urandom);
    load_weights(2);
    tick(2);
    for (int i = 0; i < 24; i++) wbuf[i] = 8'(i);
    l0 = learn_cnt;
    load_weights(1);
    tick(2);
    check_seq_weights("toggle");
    chk("toggle_learn_pulses", learn_cnt - l0, 1);
    chk("toggle_busy_after", busy, 0);

    // Reset in the middle of a weight load.
    l0 = learn_cnt;
    send_byte(8'h01, t);
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i), t);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    for (int i = 0; i < 6; i++) chk($sformatf("midload_weight%0d", i), dw[i], 0);
    chk("midload_no_learn", learn_cnt - l0, 0);
    load_weights(0);
    tick(2);
    check_seq_weights("reload");
    chk("reload_learn_pulses", learn_cnt - l0, 1);

    // Reset in the middle of WAIT.
    c0 = classify_cnt;
    result = 8'h99;
    pbuf[0] = 8'h55; pbuf[1] = 8'h66; pbuf[2] = 8'h77; pbuf[3] = 8'h88;
    load_pixels(0, t_last);
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < RL + 4; i++) begin
      @(negedge clk);
      chk("midwait_no_res_valid", res_valid, 0);
      @(posedge clk); #1;
    end
    chk("midwait_classify_pulses", classify_cnt - c0, 1);
    chk("midwait_pixels", pixels, 0);

    // Randomized command mix.
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3) begin
        for (int i = 0; i < 24; i++) wbuf[i] = 8'($urandom);
        load_weights(2);
      end else if (sel < 8) begin
        for (int i = 0; i < 4; i++) pbuf[i] = 8'($urandom);
        result = 8'($urandom);
        load_pixels(2, t_last);
        wait_resp(1'b1, t_seen);
        release_resp($urandom_range(0, 4), 1'b1);
      end else begin
        op = 8'($urandom);
        while (op == 8'h01 || op == 8'h02) op = 8'($urandom);
        send_byte(op, t);
      end
      in_valid = 1'b0;
      tick($urandom_range(0, 2));
    end
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
